// File: rtl/sb_uart_msg_tx_if.sv
// ---------------------------------------------------------------------------
// sb_uart_msg_tx_if
// Request/response and serial-line bundle for the Swachhta Bot XBee message
// transmitter.
//   tx_start    request, sampled only while ready=1
//   msg_type    0=GBI, 1=PICKUP, 2=END, 3=reserved
//   colour      0=red, 1=green, 2=blue, 3=invalid
//   bin_number  bin/node digit 0..9
//   ready       transmitter idle and able to accept tx_start
//   done        one-cycle pulse after the last stop bit of a message
//   err         one-cycle pulse when a request is rejected
//   tx          UART serial line, idles high
// master = task controller side, slave = transmitter side.
// ---------------------------------------------------------------------------
interface sb_uart_msg_tx_if;
    logic       tx_start;
    logic [1:0] msg_type;
    logic [1:0] colour;
    logic [3:0] bin_number;
    logic       ready;
    logic       done;
    logic       err;
    logic       tx;

    modport master (
        output tx_start, msg_type, colour, bin_number,
        input  ready, done, err, tx
    );

    modport slave (
        input  tx_start, msg_type, colour, bin_number,
        output ready, done, err, tx
    );
endinterface

// File: rtl/sb_uart_msg_tx.sv
// ---------------------------------------------------------------------------
// sb_uart_msg_tx
// UART message transmitter for the Swachhta Bot XBee link. On an accepted
// request the message fields are latched and a multi-character ASCII message
// is serialised as 8N1/8N2 frames, LSB first, with no gap between characters.
//   GBI    : "GBI" d "-" w "-#"   (w: red='M', green='D', blue='W')
//   PICKUP : "PU" d "-#"
//   END    : "END-#"
//   d = '0' + bin_number; optional '\n' appended when APPEND_NL=1.
// Ports
//   clk_50M  system clock
//   rst      synchronous, active-high reset (abandons any message in flight)
//   bus      sb_uart_msg_tx_if.slave: tx_start/msg_type/colour/bin_number in,
//            ready/done/err/tx out (all outputs registered)
// Parameters
//   CLKS_PER_BIT  clock cycles per UART bit (>= 2)
//   STOP_BITS     1 or 2
//   APPEND_NL     1 = append 0x0A after the final '#'
// ---------------------------------------------------------------------------
module sb_uart_msg_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int STOP_BITS    = 2,
    parameter int APPEND_NL    = 0
) (
    input  logic            clk_50M,
    input  logic            rst,
    sb_uart_msg_tx_if.slave bus
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    // Stop-bit counter is one bit wide: last index is 0 for 1 stop bit, 1 for 2.
    localparam logic STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    // Character at position idx of the message described by mt/col/bin.
    // Any position past the base message is the optional newline.
    function automatic logic [7:0] char_at(
        input logic [1:0] mt,
        input logic [1:0] col,
        input logic [3:0] bin,
        input logic [3:0] idx
    );
        logic [7:0] d;
        logic [7:0] w;
        logic [7:0] c;
        d = 8'h30 + {4'h0, bin};
        case (col)
            2'd0:    w = 8'h4D;  // 'M'
            2'd1:    w = 8'h44;  // 'D'
            2'd2:    w = 8'h57;  // 'W'
            default: w = 8'h3F;
        endcase
        case (mt)
            2'd0: begin
                case (idx)
                    4'd0:    c = 8'h47;  // 'G'
                    4'd1:    c = 8'h42;  // 'B'
                    4'd2:    c = 8'h49;  // 'I'
                    4'd3:    c = d;
                    4'd4:    c = 8'h2D;  // '-'
                    4'd5:    c = w;
                    4'd6:    c = 8'h2D;
                    4'd7:    c = 8'h23;  // '#'
                    default: c = 8'h0A;
                endcase
            end
            2'd1: begin
                case (idx)
                    4'd0:    c = 8'h50;  // 'P'
                    4'd1:    c = 8'h55;  // 'U'
                    4'd2:    c = d;
                    4'd3:    c = 8'h2D;
                    4'd4:    c = 8'h23;
                    default: c = 8'h0A;
                endcase
            end
            2'd2: begin
                case (idx)
                    4'd0:    c = 8'h45;  // 'E'
                    4'd1:    c = 8'h4E;  // 'N'
                    4'd2:    c = 8'h44;  // 'D'
                    4'd3:    c = 8'h2D;
                    4'd4:    c = 8'h23;
                    default: c = 8'h0A;
                endcase
            end
            default: c = 8'h0A;
        endcase
        return c;
    endfunction

    // Index of the final character for a message type.
    function automatic logic [3:0] last_index(input logic [1:0] mt);
        logic [3:0] base;
        case (mt)
            2'd0:    base = 4'd7;
            default: base = 4'd4;
        endcase
        return (APPEND_NL != 0) ? base + 4'd1 : base;
    endfunction

    logic [2:0]        state_r;
    logic [BAUD_W-1:0] baud_cnt_r;
    logic [2:0]        bit_idx_r;
    logic              stop_cnt_r;
    logic [3:0]        char_idx_r;
    logic [3:0]        last_idx_r;
    logic [1:0]        type_r;
    logic [1:0]        colour_r;
    logic [3:0]        bin_r;
    logic [7:0]        char_r;
    logic              ready_r;
    logic              done_r;
    logic              err_r;
    logic              tx_r;

    logic              req_ok_s;
    logic              baud_end_s;
    logic [7:0]        first_char_s;
    logic [7:0]        next_char_s;

    // Request validation and character lookup for the current/next character.
    always_comb begin
        req_ok_s = !((bus.msg_type == 2'd3) ||
                     ((bus.msg_type == 2'd0) && (bus.colour == 2'd3)) ||
                     ((bus.msg_type != 2'd2) && (bus.bin_number > 4'd9)));
        baud_end_s   = (baud_cnt_r == BAUD_LAST);
        first_char_s = char_at(bus.msg_type, bus.colour, bus.bin_number, 4'd0);
        next_char_s  = char_at(type_r, colour_r, bin_r, char_idx_r + 4'd1);
    end

    // Message FSM, baud timing and registered outputs.
    always_ff @(posedge clk_50M) begin
        if (rst) begin
            state_r    <= S_IDLE;
            baud_cnt_r <= '0;
            bit_idx_r  <= 3'd0;
            stop_cnt_r <= 1'b0;
            char_idx_r <= 4'd0;
            last_idx_r <= 4'd0;
            type_r     <= 2'd0;
            colour_r   <= 2'd0;
            bin_r      <= 4'd0;
            char_r     <= 8'h00;
            ready_r    <= 1'b1;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            tx_r       <= 1'b1;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    baud_cnt_r <= '0;
                    if (bus.tx_start) begin
                        if (req_ok_s) begin
                            type_r     <= bus.msg_type;
                            colour_r   <= bus.colour;
                            bin_r      <= bus.bin_number;
                            char_r     <= first_char_s;
                            char_idx_r <= 4'd0;
                            last_idx_r <= last_index(bus.msg_type);
                            ready_r    <= 1'b0;
                            tx_r       <= 1'b0;  // start bit begins immediately
                            state_r    <= S_START;
                        end else begin
                            err_r <= 1'b1;
                        end
                    end
                end
                S_START: begin
                    if (baud_end_s) begin
                        baud_cnt_r <= '0;
                        bit_idx_r  <= 3'd0;
                        tx_r       <= char_r[0];
                        state_r    <= S_DATA;
                    end else begin
                        baud_cnt_r <= baud_cnt_r + 1'b1;
                    end
                end
                S_DATA: begin
                    if (baud_end_s) begin
                        baud_cnt_r <= '0;
                        if (bit_idx_r == 3'd7) begin
                            tx_r       <= 1'b1;
                            stop_cnt_r <= 1'b0;
                            state_r    <= S_STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                            tx_r      <= char_r[bit_idx_r + 3'd1];
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + 1'b1;
                    end
                end
                S_STOP: begin
                    if (baud_end_s) begin
                        baud_cnt_r <= '0;
                        if (stop_cnt_r == STOP_LAST) begin
                            if (char_idx_r == last_idx_r) begin
                                state_r <= S_DONE;
                            end else begin
                                // Next start bit follows the last stop bit directly.
                                char_idx_r <= char_idx_r + 4'd1;
                                char_r     <= next_char_s;
                                tx_r       <= 1'b0;
                                state_r    <= S_START;
                            end
                        end else begin
                            stop_cnt_r <= 1'b1;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + 1'b1;
                    end
                end
                S_DONE: begin
                    // done and ready appear together; a request in that cycle is taken.
                    done_r  <= 1'b1;
                    ready_r <= 1'b1;
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                    ready_r <= 1'b1;
                    tx_r    <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ready = ready_r;
    assign bus.done  = done_r;
    assign bus.err   = err_r;
    assign bus.tx    = tx_r;

endmodule

// File: tb/tb_sb_uart_msg_tx.sv
module tb_sb_uart_msg_tx;

    logic clk_50M = 1'b0;
    always #10 clk_50M = ~clk_50M;

    logic       rst;
    logic       tx_start;
    logic [1:0] msg_type;
    logic [1:0] colour;
    logic [3:0] bin_number;

    int n_cmp = 0;
    int n_bad = 0;
    int sel;

    sb_uart_msg_tx_if bus_a ();
    sb_uart_msg_tx_if bus_b ();
    sb_uart_msg_tx_if bus_c ();

    assign bus_a.tx_start = tx_start;   assign bus_a.msg_type = msg_type;
    assign bus_a.colour = colour;       assign bus_a.bin_number = bin_number;
    assign bus_b.tx_start = tx_start;   assign bus_b.msg_type = msg_type;
    assign bus_b.colour = colour;       assign bus_b.bin_number = bin_number;
    assign bus_c.tx_start = tx_start;   assign bus_c.msg_type = msg_type;
    assign bus_c.colour = colour;       assign bus_c.bin_number = bin_number;

    // A: defaults (434 clk/bit, 2 stop, no NL); B: 4/1/NL; C: 5/2/no NL
    sb_uart_msg_tx dut_a (.clk_50M(clk_50M), .rst(rst), .bus(bus_a));
    sb_uart_msg_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1), .APPEND_NL(1))
        dut_b (.clk_50M(clk_50M), .rst(rst), .bus(bus_b));
    sb_uart_msg_tx #(.CLKS_PER_BIT(5), .STOP_BITS(2), .APPEND_NL(0))
        dut_c (.clk_50M(clk_50M), .rst(rst), .bus(bus_c));

    logic tx_m, ready_m, done_m, err_m;

    // Observe the instance under test.
    always_comb begin
        case (sel)
            0: begin tx_m = bus_a.tx; ready_m = bus_a.ready; done_m = bus_a.done; err_m = bus_a.err; end
            1: begin tx_m = bus_b.tx; ready_m = bus_b.ready; done_m = bus_b.done; err_m = bus_b.err; end
            default: begin tx_m = bus_c.tx; ready_m = bus_c.ready; done_m = bus_c.done; err_m = bus_c.err; end
        endcase
    end

    typedef struct packed {
        logic [1:0]  mt;
        logic [1:0]  col;
        logic [3:0]  bin;
        logic        rej;
        logic [3:0]  n;
        logic [71:0] msg;
    } vec_t;

    vec_t tab [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the sampling edge.
    task automatic start_req(input logic [1:0] mt, input logic [1:0] col,
                             input logic [3:0] bin, input bit hold);
        msg_type = mt; colour = col; bin_number = bin; tx_start = 1'b1;
        @(negedge clk_50M);
        if (!hold) tx_start = 1'b0;
    endtask

    task automatic do_reset(input string nm);
        rst = 1'b1; tx_start = 1'b0;
        repeat (2) @(negedge clk_50M);
        chk({nm, " reset tx"}, tx_m, 1);
        chk({nm, " reset ready"}, ready_m, 1);
        chk({nm, " reset done"}, done_m, 0);
        chk({nm, " reset err"}, err_m, 0);
        rst = 1'b0;
        @(negedge clk_50M);
    endtask

    // Starts at the cycle after acceptance (k=0); cycle-exact line model,
    // ends at the done cycle (k=len+1).
    task automatic check_msg(input int cpb, input int sb, input logic [71:0] msg,
                             input int n, input string nm);
        int fb, len, bp, ci, b;
        int bad_tx, bad_rdy, bad_done, bad_err;
        logic e_tx;
        logic [7:0] ch;
        logic [7:0] dec [16];
        fb = 9 + sb;
        len = n * fb * cpb;
        bad_tx = 0; bad_rdy = 0; bad_done = 0; bad_err = 0;
        for (int i = 0; i < 16; i++) dec[i] = 8'h00;
        for (int k = 0; k <= len + 1; k++) begin
            bp = k / cpb; ci = bp / fb; b = bp % fb;
            if (k >= len) e_tx = 1'b1;
            else begin
                ch = msg[(n - 1 - ci) * 8 +: 8];
                if (b == 0) e_tx = 1'b0;
                else if (b <= 8) e_tx = ch[b - 1];
                else e_tx = 1'b1;
                if (b >= 1 && b <= 8 && (k % cpb) == cpb / 2) dec[ci][b - 1] = tx_m;
            end
            if (tx_m !== e_tx) bad_tx++;
            if (ready_m !== (k >= len + 1)) bad_rdy++;
            if (done_m !== (k == len + 1)) bad_done++;
            if (err_m !== 1'b0) bad_err++;
            if (k < len + 1) @(negedge clk_50M);
        end
        for (int c = 0; c < n; c++)
            chk($sformatf("%s char%0d", nm, c), dec[c], msg[(n - 1 - c) * 8 +: 8]);
        chk({nm, " tx bad cycles"}, bad_tx, 0);
        chk({nm, " ready bad cycles"}, bad_rdy, 0);
        chk({nm, " done bad cycles"}, bad_done, 0);
        chk({nm, " err bad cycles"}, bad_err, 0);
    endtask

    // Called at the cycle after a rejected request.
    task automatic check_reject(input string nm);
        chk({nm, " err pulse"}, err_m, 1);
        chk({nm, " tx idle"}, tx_m, 1);
        chk({nm, " ready held"}, ready_m, 1);
        @(negedge clk_50M);
        chk({nm, " err cleared"}, err_m, 0);
        chk({nm, " no done"}, done_m, 0);
    endtask

    task automatic check_quiet(input string nm, input int cycles);
        int bad;
        bad = 0;
        for (int k = 0; k < cycles; k++) begin
            if (tx_m !== 1'b1 || ready_m !== 1'b1 || done_m !== 1'b0 || err_m !== 1'b0) bad++;
            @(negedge clk_50M);
        end
        chk({nm, " quiet bad cycles"}, bad, 0);
    endtask

    initial begin
        tab[0]  = '{mt: 2'd0, col: 2'd0, bin: 4'd1,  rej: 1'b0, n: 4'd9, msg: 72'("GBI1-M-#\n")};
        tab[1]  = '{mt: 2'd1, col: 2'd0, bin: 4'd7,  rej: 1'b0, n: 4'd6, msg: 72'("PU7-#\n")};
        tab[2]  = '{mt: 2'd2, col: 2'd0, bin: 4'd0,  rej: 1'b0, n: 4'd6, msg: 72'("END-#\n")};
        tab[3]  = '{mt: 2'd0, col: 2'd1, bin: 4'd0,  rej: 1'b0, n: 4'd9, msg: 72'("GBI0-D-#\n")};
        tab[4]  = '{mt: 2'd0, col: 2'd2, bin: 4'd9,  rej: 1'b0, n: 4'd9, msg: 72'("GBI9-W-#\n")};
        tab[5]  = '{mt: 2'd1, col: 2'd3, bin: 4'd9,  rej: 1'b0, n: 4'd6, msg: 72'("PU9-#\n")};
        tab[6]  = '{mt: 2'd2, col: 2'd3, bin: 4'd15, rej: 1'b0, n: 4'd6, msg: 72'("END-#\n")};
        tab[7]  = '{mt: 2'd3, col: 2'd0, bin: 4'd1,  rej: 1'b1, n: 4'd0, msg: 72'd0};
        tab[8]  = '{mt: 2'd0, col: 2'd3, bin: 4'd2,  rej: 1'b1, n: 4'd0, msg: 72'd0};
        tab[9]  = '{mt: 2'd0, col: 2'd0, bin: 4'd10, rej: 1'b1, n: 4'd0, msg: 72'd0};
        tab[10] = '{mt: 2'd1, col: 2'd0, bin: 4'd12, rej: 1'b1, n: 4'd0, msg: 72'd0};
        tab[11] = '{mt: 2'd1, col: 2'd0, bin: 4'd0,  rej: 1'b0, n: 4'd6, msg: 72'("PU0-#\n")};

        rst = 1'b1; tx_start = 1'b0; msg_type = 2'd0; colour = 2'd0; bin_number = 4'd0;
        sel = 0;
        @(negedge clk_50M);

        // T1: default parameters, GBI red bin 1, exact 434-cycle bits
        do_reset("t1");
        start_req(2'd0, 2'd0, 4'd1, 1'b0);
        check_msg(434, 2, 72'("GBI1-M-#"), 8, "t1");
        @(negedge clk_50M);
        chk("t1 done one cycle", done_m, 0);

        // Table on instance B (includes T2: "PU7-#\n")
        sel = 1;
        do_reset("tab");
        for (int i = 0; i < 12; i++) begin
            start_req(tab[i].mt, tab[i].col, tab[i].bin, 1'b0);
            if (tab[i].rej) check_reject($sformatf("vec%0d", i));
            else begin
                check_msg(4, 1, tab[i].msg, int'(tab[i].n), $sformatf("vec%0d", i));
                @(negedge clk_50M);
                chk($sformatf("vec%0d done cleared", i), done_m, 0);
                chk($sformatf("vec%0d ready idle", i), ready_m, 1);
            end
        end

        // T3: request during a message is ignored, late field changes ignored
        sel = 2;
        do_reset("t3");
        start_req(2'd2, 2'd0, 4'd0, 1'b0);
        msg_type = 2'd0; colour = 2'd1; bin_number = 4'd4;
        fork
            check_msg(5, 2, 72'("END-#"), 5, "t3");
            begin
                repeat (100) @(negedge clk_50M);
                tx_start = 1'b1;
                @(negedge clk_50M);
                tx_start = 1'b0;
            end
        join
        @(negedge clk_50M);
        check_quiet("t3", 60);

        // T4: three rejected requests
        start_req(2'd3, 2'd0, 4'd0, 1'b0);  check_reject("t4 type3");
        start_req(2'd0, 2'd3, 4'd2, 1'b0);  check_reject("t4 colour3");
        start_req(2'd0, 2'd0, 4'd12, 1'b0); check_reject("t4 bin12");
        check_quiet("t4", 20);

        // T5: reset during 3rd data bit of the 2nd char ('B' bit2 = 0)
        start_req(2'd0, 2'd0, 4'd3, 1'b0);
        repeat (72) @(negedge clk_50M);
        chk("t5 tx before reset", tx_m, 0);
        rst = 1'b1;
        @(negedge clk_50M);
        chk("t5 tx after reset", tx_m, 1);
        chk("t5 ready after reset", ready_m, 1);
        chk("t5 done after reset", done_m, 0);
        rst = 1'b0;
        @(negedge clk_50M);
        check_quiet("t5", 40);
        start_req(2'd0, 2'd2, 4'd9, 1'b0);
        check_msg(5, 2, 72'("GBI9-W-#"), 8, "t5");
        @(negedge clk_50M);

        // T6: tx_start held high -> back-to-back END messages
        start_req(2'd2, 2'd0, 4'd0, 1'b1);
        for (int m = 0; m < 3; m++) begin
            check_msg(5, 2, 72'("END-#"), 5, $sformatf("t6 msg%0d", m));
            if (m == 2) tx_start = 1'b0;
            @(negedge clk_50M);
        end
        chk("t6 idle tx", tx_m, 1);
        chk("t6 idle ready", ready_m, 1);
        check_quiet("t6", 30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
